// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC fetch types, field bounds and decode helpers
package wisc_pkg;
    localparam int INSTR_W   = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 11;
    localparam int FUNCT_MSB = 1;
    localparam int FUNCT_LSB = 0;
    localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 5'b00000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of {instr, pc_plus2} with registered head
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - WISC fetch stage: PC, single-outstanding imem requests, decode buffer
module fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [15:0] dec_instr,
    output logic [4:0]  dec_opcode,
    output logic [1:0]  dec_funct,
    output logic [15:0] dec_pc_plus2,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted,
    output logic        err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t  state, state_nxt;
    logic [15:0]   pc;
    logic [15:0]   pend_pc2;
    logic          halt_seen;
    logic          err_q;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic          accept, push, pop, rv_halt, req_state_ok;
    logic [OW-1:0] occupancy;

    assign rv_halt      = imem_rvalid && is_halt(imem_rdata);
    assign push         = !redirect && (state == ST_WAIT) && imem_rvalid;
    assign pop          = !redirect && dec_valid && dec_ready;
    // A same-cycle push counts against space, so every accepted request owns a slot.
    assign occupancy    = {1'b0, count} + OW'(push);
    assign req_state_ok = (state == ST_RUN) || ((state == ST_WAIT) && imem_rvalid);
    assign imem_req     = rst_n && req_state_ok && (occupancy < OW'(DEPTH))
                          && !halt_seen && !redirect && !rv_halt;
    assign accept       = imem_req && imem_gnt;
    assign imem_addr    = pc;

    fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, pend_pc2}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign dec_valid    = (count != '0) && (state != ST_HALT);
    assign dec_instr    = head[31:16];
    assign dec_pc_plus2 = head[15:0];
    assign dec_opcode   = dec_instr[OPC_MSB:OPC_LSB];
    assign dec_funct    = dec_instr[FUNCT_MSB:FUNCT_LSB];
    assign halted       = (state == ST_HALT);
    assign err          = err_q;

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            // An outstanding response that has not shown up yet must be swallowed.
            state_nxt = ((state == ST_WAIT || state == ST_DRAIN) && !imem_rvalid) ? ST_DRAIN : ST_RUN;
        end else if (pop && is_halt(dec_instr)) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_RUN:   if (accept) state_nxt = ST_WAIT;
                ST_WAIT:  if (imem_rvalid) state_nxt = accept ? ST_WAIT : ST_RUN;
                ST_DRAIN: if (imem_rvalid) state_nxt = ST_RUN;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            pend_pc2  <= '0;
            halt_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (imem_rvalid && (state == ST_RUN || state == ST_HALT)) begin
                err_q <= 1'b1;
            end
            if (redirect) begin
                pc        <= redirect_pc;
                halt_seen <= 1'b0;
            end else begin
                if (accept) begin
                    pc       <= pc + 16'd2;
                    pend_pc2 <= pc + 16'd2;
                end
                if (push && is_halt(imem_rdata)) begin
                    halt_seen <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [4:0]  dec_opcode;
    logic [1:0]  dec_funct;
    logic [15:0] dec_pc_plus2;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        err;

    logic        auto_mem;
    logic        t_rvalid;
    logic [15:0] t_rdata;
    logic        m_rvalid;
    logic [15:0] m_rdata;
    logic [15:0] halt_addr;

    logic [15:0] acc_q [$];
    logic [31:0] pop_q [$];
    int          acc_base, pop_base;
    int          n_chk, n_pass, n_fail;
    int          k, req_seen;

    always #5 clk = ~clk;

    assign imem_rvalid = auto_mem ? m_rvalid : t_rvalid;
    assign imem_rdata  = auto_mem ? m_rdata  : t_rdata;

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_opcode   (dec_opcode),
        .dec_funct    (dec_funct),
        .dec_pc_plus2 (dec_pc_plus2),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halted       (halted),
        .err          (err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid <= 1'b0;
            m_rdata  <= 16'h0000;
        end else begin
            m_rvalid <= auto_mem && imem_req && imem_gnt;
            m_rdata  <= (imem_addr == halt_addr) ? 16'h0000 : (16'h4000 | imem_addr);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req && imem_gnt) acc_q.push_back(imem_addr);
            if (dec_valid && dec_ready) pop_q.push_back({dec_instr, dec_pc_plus2});
        end
    end

    task automatic pass_chk();
        n_chk++;
        n_pass++;
    endtask

    task automatic fail_chk(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s", tag);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        acc_base = acc_q.size();
        pop_base = pop_q.size();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0; imem_gnt = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; auto_mem = 1'b0; t_rvalid = 1'b0; t_rdata = 16'h0000;
        halt_addr = 16'hFFFF;

        step();
        if (imem_req === 1'b0) pass_chk(); else fail_chk("rst_req");
        if (imem_addr === 16'h0000) pass_chk(); else fail_chk("rst_addr");
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("rst_dec_valid");
        if (halted === 1'b0) pass_chk(); else fail_chk("rst_halted");
        if (err === 1'b0) pass_chk(); else fail_chk("rst_err");

        auto_mem = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1;
        do_reset();
        if (imem_req === 1'b1) pass_chk(); else fail_chk("t1_req0");
        if (imem_addr === 16'h0000) pass_chk(); else fail_chk("t1_addr0");
        step();
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("t1_latency");
        step();
        if (dec_valid === 1'b1) pass_chk(); else fail_chk("t1_valid");
        if (dec_instr === 16'h4000) pass_chk(); else fail_chk("t1_instr0");
        if (dec_opcode === 5'h08) pass_chk(); else fail_chk("t1_opcode0");
        if (dec_pc_plus2 === 16'h0002) pass_chk(); else fail_chk("t1_pc2_0");
        step();
        if (dec_instr === 16'h4002) pass_chk(); else fail_chk("t1_instr1");
        if (dec_funct === 2'b10) pass_chk(); else fail_chk("t1_funct1");
        step(10);
        if ((acc_q.size() - acc_base >= 4) === 1'b1) pass_chk(); else fail_chk("t1_nacc");
        if (acc_q[acc_base + 0] === 16'h0000) pass_chk(); else fail_chk("t1_acc0");
        if (acc_q[acc_base + 1] === 16'h0002) pass_chk(); else fail_chk("t1_acc1");
        if (acc_q[acc_base + 2] === 16'h0004) pass_chk(); else fail_chk("t1_acc2");
        if (acc_q[acc_base + 3] === 16'h0006) pass_chk(); else fail_chk("t1_acc3");
        if ((pop_q.size() - pop_base >= 4) === 1'b1) pass_chk(); else fail_chk("t1_npop");
        if (pop_q[pop_base + 0] === 32'h4000_0002) pass_chk(); else fail_chk("t1_pop0");
        if (pop_q[pop_base + 1] === 32'h4002_0004) pass_chk(); else fail_chk("t1_pop1");
        if (pop_q[pop_base + 2] === 32'h4004_0006) pass_chk(); else fail_chk("t1_pop2");
        if (pop_q[pop_base + 3] === 32'h4006_0008) pass_chk(); else fail_chk("t1_pop3");

        dec_ready = 1'b0;
        do_reset();
        step(6);
        if (acc_q.size() - acc_base === 2) pass_chk(); else fail_chk("t2_nacc");
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t2_req_off");
        if (dec_valid === 1'b1) pass_chk(); else fail_chk("t2_valid");
        if (dec_instr === 16'h4000) pass_chk(); else fail_chk("t2_hold");
        dec_ready = 1'b1;
        #1;
        if (dec_instr === 16'h4000) pass_chk(); else fail_chk("t2_head0");
        step();
        if (dec_instr === 16'h4002) pass_chk(); else fail_chk("t2_head1");
        if (imem_req === 1'b1) pass_chk(); else fail_chk("t2_resume_req");
        if (imem_addr === 16'h0004) pass_chk(); else fail_chk("t2_resume_addr");
        step(4);
        if (acc_q[acc_base + 2] === 16'h0004) pass_chk(); else fail_chk("t2_acc2");
        if (pop_q[pop_base + 0] === 32'h4000_0002) pass_chk(); else fail_chk("t2_pop0");
        if (pop_q[pop_base + 1] === 32'h4002_0004) pass_chk(); else fail_chk("t2_pop1");

        auto_mem = 1'b0; imem_gnt = 1'b1; dec_ready = 1'b1;
        do_reset();
        step();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t3_req_redirect");
        step();
        redirect = 1'b0;
        #1;
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t3_req_drain");
        step(2);
        t_rvalid = 1'b1; t_rdata = 16'hBEEF;
        #1;
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t3_req_discard");
        step();
        t_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("t3_no_beef");
        if (imem_req === 1'b1) pass_chk(); else fail_chk("t3_req_new");
        if (imem_addr === 16'h0100) pass_chk(); else fail_chk("t3_addr_new");
        step();
        imem_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 16'h0801;
        step();
        t_rvalid = 1'b0;
        #1;
        if (dec_valid === 1'b1) pass_chk(); else fail_chk("t3_valid");
        if (dec_instr === 16'h0801) pass_chk(); else fail_chk("t3_instr");
        if (dec_pc_plus2 === 16'h0102) pass_chk(); else fail_chk("t3_pc2");
        if (dec_opcode === 5'h01) pass_chk(); else fail_chk("t3_opcode");
        if (dec_funct === 2'b01) pass_chk(); else fail_chk("t3_funct");
        if (err === 1'b0) pass_chk(); else fail_chk("t3_err");
        if (acc_q[acc_base + 1] === 16'h0100) pass_chk(); else fail_chk("t3_acc1");

        auto_mem = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1; halt_addr = 16'h0006;
        do_reset();
        k = 0;
        while (!(dec_valid && dec_opcode == 5'd0) && k < 20) begin
            step();
            k++;
        end
        if ((dec_valid && dec_opcode == 5'd0) === 1'b1) pass_chk(); else fail_chk("t4_halt_seen");
        if (dec_pc_plus2 === 16'h0008) pass_chk(); else fail_chk("t4_halt_pc2");
        step();
        if (halted === 1'b1) pass_chk(); else fail_chk("t4_halted");
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("t4_dec_off");
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) req_seen++;
            step();
        end
        if (req_seen === 0) pass_chk(); else fail_chk("t4_req_quiet");
        if (acc_q.size() - acc_base === 4) pass_chk(); else fail_chk("t4_nacc");
        if (acc_q[acc_base + 3] === 16'h0006) pass_chk(); else fail_chk("t4_last_acc");
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1;
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t4_req_redirect");
        step();
        redirect = 1'b0;
        #1;
        if (halted === 1'b0) pass_chk(); else fail_chk("t4_unhalted");
        if (imem_req === 1'b1) pass_chk(); else fail_chk("t4_req_resume");
        if (imem_addr === 16'h0040) pass_chk(); else fail_chk("t4_addr_resume");

        auto_mem = 1'b0; imem_gnt = 1'b0; halt_addr = 16'hFFFF;
        do_reset();
        t_rvalid = 1'b1; t_rdata = 16'h5555;
        #1;
        if (err === 1'b0) pass_chk(); else fail_chk("t5_err_before");
        step();
        t_rvalid = 1'b0; auto_mem = 1'b1; imem_gnt = 1'b1;
        #1;
        if (err === 1'b1) pass_chk(); else fail_chk("t5_err_set");
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("t5_dropped");
        step(12);
        if (err === 1'b1) pass_chk(); else fail_chk("t5_err_sticky");
        if (pop_q[pop_base + 0] === 32'h4000_0002) pass_chk(); else fail_chk("t5_pop0");
        if (pop_q[pop_base + 1] === 32'h4002_0004) pass_chk(); else fail_chk("t5_pop1");

        auto_mem = 1'b0; imem_gnt = 1'b0; dec_ready = 1'b0;
        do_reset();
        t_rvalid = 1'b1; t_rdata = 16'h5555;
        step();
        t_rvalid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 16'h1111;
        step();
        t_rvalid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #1;
        if (dec_valid === 1'b1) pass_chk(); else fail_chk("t6_pre_valid");
        if (dec_instr === 16'h1111) pass_chk(); else fail_chk("t6_pre_instr");
        if (err === 1'b1) pass_chk(); else fail_chk("t6_pre_err");
        if (imem_addr === 16'h0004) pass_chk(); else fail_chk("t6_pre_addr");
        #2;
        rst_n = 1'b0;
        #1;
        if (imem_req === 1'b0) pass_chk(); else fail_chk("t6_rst_req");
        if (imem_addr === 16'h0000) pass_chk(); else fail_chk("t6_rst_addr");
        if (dec_valid === 1'b0) pass_chk(); else fail_chk("t6_rst_valid");
        if (dec_instr === 16'h0000) pass_chk(); else fail_chk("t6_rst_instr");
        if (err === 1'b0) pass_chk(); else fail_chk("t6_rst_err");
        if (halted === 1'b0) pass_chk(); else fail_chk("t6_rst_halted");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        if (imem_req === 1'b1) pass_chk(); else fail_chk("t6_post_req");
        if (imem_addr === 16'h0000) pass_chk(); else fail_chk("t6_post_addr");
        if (err === 1'b0) pass_chk(); else fail_chk("t6_post_err");
        imem_gnt = 1'b1;
        step();
        if (acc_q[acc_q.size() - 1] === 16'h0000) pass_chk(); else fail_chk("t6_first_acc");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the WISC 16-bit pipeline. It drives the PC, issues requests to a multicycle instruction memory, and buffers returned words. It presents instructions to the decode/control stage, which consumes opcode = instr[15:11] and funct = instr[1:0]. It handles redirects from branch/jump resolution, and stops fetching once a HALT is fetched.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
imem_req  out  1  fetch request valid
imem_addr  out  16  fetch address (current PC)
imem_gnt  in  1  memory accepts request this cycle (req & gnt = accept)
imem_rvalid  in  1  read data valid, in order, >=1 cycle after accept
imem_rdata  in  16  instruction word
dec_valid  out  1  buffer head valid
dec_ready  in  1  decode consumes head (valid & ready = pop)
dec_instr  out  16  head instruction
dec_opcode  out  5  dec_instr[15:11]
dec_funct  out  2  dec_instr[1:0]
dec_pc_plus2  out  16  fetch address of head + 2
redirect  in  1  flush and restart fetch
redirect_pc  in  16  new PC, sampled when redirect=1
halted  out  1  HALT consumed, fetch stopped
err  out  1  sticky protocol error

Behaviour:
- Reset (async assert): pc=RESET_PC, buffer empty, outstanding=0, state RUN, halt_seen=0, halted=0, err=0. All outputs 0 except imem_addr=RESET_PC.
- At most one outstanding request. FSM states:
  - RUN: no request outstanding.
  - WAIT: one request accepted, response pending.
  - DRAIN: pending response must be discarded.
  - HALT: fetch stopped.
- imem_req=1 iff all hold: state RUN; count < DEPTH; halt_seen=0; redirect=0; and not (rvalid carrying opcode 00000 this cycle).
- Accept (req & gnt): pc <= pc+2 (16-bit wrap, 0xFFFE -> 0x0000); remember accepted addr; RUN->WAIT.
- imem_req and imem_addr stay stable until gnt, except on redirect.
- Buffer space is reserved at accept, so a push never finds the buffer full.
- WAIT & rvalid: push {rdata, addr+2}; WAIT->RUN. If rdata[15:11]==5'b00000, set halt_seen.
  - A new request may be issued in the same cycle (the state is treated as RUN for the req equation only when rvalid=1 and the word is not HALT).
- Latency: rvalid in cycle N -> dec_valid=1 in cycle N+1. Buffer output is registered; no rdata->dec bypass.
- Pop and push in the same cycle: count is unchanged, ordering is preserved.
- dec_* outputs are stable while dec_valid=1 and dec_ready=0.
- Pop of an entry with opcode 00000: state -> HALT, halted=1 from the next cycle, imem_req=0, dec_valid=0.
- Redirect has highest priority and applies in any state:
  - Flush buffer; clear halt_seen; pc <= redirect_pc; halted <= 0.
  - Ignore push/pop that cycle; no request that cycle.
  - If a response is outstanding and does not arrive that same cycle: -> DRAIN; otherwise -> RUN.
- DRAIN & rvalid: discard data; -> RUN. A redirect during DRAIN stays in DRAIN with the new pc.
- Redirect in HALT resumes fetch at redirect_pc (squashed HALT).
- err: set when rvalid=1 in RUN or HALT (no outstanding request); cleared only by reset. Fetch continues and the stray data is dropped.
- Reset asserted mid-transaction: all state cleared immediately. The memory side is reset by the same rst_n.

Decomposition:
- Package wisc_pkg:
  - INSTR_W=16
  - OPC_HALT=5'b00000
  - opcode/funct field bounds
  - fetch_state_t enum {RUN, WAIT, DRAIN, HALT}
- Sub-module fetch_fifo:
  - DEPTH entries of {instr[15:0], pc_plus2[15:0]}
  - push/pop/flush inputs; count output; registered head

Test Plan:
1. Streaming: gnt=1, rvalid one cycle after each accept, rdata=0x4000|addr, dec_ready=1 -> addresses 0,2,4,6; dec_pc_plus2 2,4,6,8; one instruction every 2 cycles; no drops or duplicates.
2. Backpressure: dec_ready=0 -> exactly 2 accepts, then imem_req=0 with dec_instr held. dec_ready=1 -> entries in order, fetch resumes at 0x0004.
3. Redirect in WAIT to 0x0100; memory returns 0xBEEF 3 cycles later -> 0xBEEF is never on dec_instr; next accepted addr 0x0100; dec_pc_plus2=0x0102.
4. HALT: word at 0x0006 = 0x0000 -> no request for 0x0008; pop of the HALT -> halted=1 next cycle, imem_req=0 for 20 cycles. Then redirect to 0x0040 -> halted=0, next addr 0x0040.
5. Stray rvalid in RUN -> err=1 and stays 1 through subsequent traffic; streaming is unaffected.
6. rst_n pulsed low during WAIT (asynchronous, between clock edges) -> outputs clear immediately; after release, first request addr=RESET_PC; err=0.
